// File: rtl/icarus_mem_pkg.sv
// icarus_mem_pkg: shared ByteSel encodings, memory-stage FSM states, byte-enable constants
package icarus_mem_pkg;
   typedef enum logic [1:0] {
      BS_WORD  = 2'b00,
      BS_HALF  = 2'b01,
      BS_BYTE  = 2'b10,
      BS_BYTEU = 2'b11
   } byte_sel_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [3:0] BE_ALL = 4'b1111;
   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_B0  = 4'b0001;

   // Conflicting command or address not aligned to the access size
   function automatic logic access_illegal(input logic rd, input logic wr,
                                           input logic [1:0] bs, input logic [1:0] a);
      return (rd & wr) | (bs == BS_WORD && a != 2'b00) | (bs == BS_HALF && a[0]);
   endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane replication/byte enables and load lane extraction/extension
module mem_lane_align
   import icarus_mem_pkg::*;
(
   input  logic [1:0]  byte_sel,
   input  logic [1:0]  lane,
   input  logic        write,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] wdata_rep,
   output logic [3:0]  byte_en,
   output logic [31:0] rdata_fmt
);
   logic [15:0] sh;

   // Shift the addressed lane down, then size/extend; replicate store data across lanes
   always_comb begin
      sh        = 16'(rdata >> {lane, 3'b000});
      rdata_fmt = byte_sel == BS_WORD ? rdata :
                  byte_sel == BS_HALF ? {{16{sh[15]}}, sh} :
                  byte_sel == BS_BYTE ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      wdata_rep = byte_sel == BS_WORD ? wdata :
                  byte_sel == BS_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
      byte_en   = (!write || byte_sel == BS_WORD) ? BE_ALL :
                  byte_sel == BS_HALF ? (lane[1] ? BE_HI : BE_LO) : BE_B0 << lane;
   end
endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access: one req/ack data-memory transaction per instruction; bus abort timer under MEM_TIMEOUT_EN
module mem_stage_access
   import icarus_mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              MemRead_In,
   input  logic              MemWrite_In,
   input  logic [1:0]        ByteSel_In,
   input  logic [31:0]       ALUResult_In,
   input  logic [31:0]       WriteData_In,
   output logic              Stall,
   output logic [31:0]       ReadData_Out,
   output logic              ReadValid_Out,
   output logic              Misalign_Out,
   output logic              Timeout_Out,
   output logic              DMem_Req,
   output logic              DMem_We,
   output logic [ADDR_W-1:0] DMem_Addr,
   output logic [31:0]       DMem_WData,
   output logic [3:0]        DMem_ByteEn,
   input  logic              DMem_Ack,
   input  logic [31:0]       DMem_RData
);
   state_t            state;
   logic              cmd_we;
   logic [1:0]        cmd_bs;
   logic [ADDR_W-1:0] cmd_addr;
   logic [31:0]       cmd_wdata;
   logic              access, illegal, req, to_hit;
   logic [31:0]       wdata_rep, rdata_fmt;
   logic [3:0]        byte_en;

   assign access      = MemRead_In | MemWrite_In;
   assign illegal     = access_illegal(MemRead_In, MemWrite_In, ByteSel_In, ALUResult_In[1:0]);
   assign req         = state == ST_WAIT;
   assign Stall       = Reset & (req | (state == ST_IDLE & access & ~illegal));
   assign DMem_Req    = req;
   assign DMem_We     = req & cmd_we;
   assign DMem_Addr   = req ? {cmd_addr[ADDR_W-1:2], 2'b00} : '0;
   assign DMem_WData  = req ? wdata_rep : '0;
   assign DMem_ByteEn = req ? byte_en : '0;

   mem_lane_align u_align (
      .byte_sel  (cmd_bs),
      .lane      (cmd_addr[1:0]),
      .write     (cmd_we),
      .wdata     (cmd_wdata),
      .rdata     (DMem_RData),
      .wdata_rep (wdata_rep),
      .byte_en   (byte_en),
      .rdata_fmt (rdata_fmt)
   );

   // Sequence IDLE/WAIT/DONE, latch the command on entry and register the result pulses
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state         <= ST_IDLE;
         cmd_we        <= 1'b0;
         cmd_bs        <= 2'b00;
         cmd_addr      <= '0;
         cmd_wdata     <= '0;
         Misalign_Out  <= 1'b0;
         ReadValid_Out <= 1'b0;
         ReadData_Out  <= '0;
      end else begin
         Misalign_Out  <= 1'b0;
         ReadValid_Out <= 1'b0;
         case (state)
            ST_IDLE:
               if (access && illegal) Misalign_Out <= 1'b1;
               else if (access) begin
                  state     <= ST_WAIT;
                  cmd_we    <= MemWrite_In;
                  cmd_bs    <= ByteSel_In;
                  cmd_addr  <= ALUResult_In[ADDR_W-1:0];
                  cmd_wdata <= WriteData_In;
               end
            ST_WAIT:
               if (DMem_Ack) begin
                  state         <= ST_DONE;
                  ReadValid_Out <= ~cmd_we;
                  if (!cmd_we) ReadData_Out <= rdata_fmt;
               end else if (to_hit) state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] to_cnt;
   assign to_hit = to_cnt == 8'(TIMEOUT_CYCLES - 1);

   // Count unacknowledged WAIT cycles from zero on each WAIT entry; abort on the limit
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         to_cnt      <= '0;
         Timeout_Out <= 1'b0;
      end else begin
         to_cnt      <= req ? to_cnt + 8'd1 : 8'd0;
         Timeout_Out <= req & ~DMem_Ack & to_hit;
      end
   end
`else
   assign to_hit      = 1'b0;
   assign Timeout_Out = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed and random load/store transactions against a byte-level reference model
module tb_mem_stage_access;
   logic        Clock, Reset;
   logic        MemRead_In, MemWrite_In;
   logic [1:0]  ByteSel_In;
   logic [31:0] ALUResult_In, WriteData_In;
   logic        Stall;
   logic [31:0] ReadData_Out;
   logic        ReadValid_Out, Misalign_Out, Timeout_Out;
   logic        DMem_Req, DMem_We;
   logic [31:0] DMem_Addr, DMem_WData;
   logic [3:0]  DMem_ByteEn;
   logic        DMem_Ack;
   logic [31:0] DMem_RData;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_load = 32'd0;

   mem_stage_access #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
      .Clock(Clock), .Reset(Reset),
      .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In), .ByteSel_In(ByteSel_In),
      .ALUResult_In(ALUResult_In), .WriteData_In(WriteData_In),
      .Stall(Stall), .ReadData_Out(ReadData_Out), .ReadValid_Out(ReadValid_Out),
      .Misalign_Out(Misalign_Out), .Timeout_Out(Timeout_Out),
      .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
      .DMem_WData(DMem_WData), .DMem_ByteEn(DMem_ByteEn),
      .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [1:0] bs);
      return bs == 2'd0 ? 4 : bs == 2'd1 ? 2 : 1;
   endfunction

   function automatic logic is_illegal(input logic rd, input logic wr, input logic [1:0] bs,
                                       input logic [31:0] a);
      return (rd && wr) || (int'(a[1:0]) % size_of(bs) != 0);
   endfunction

   // bytes [a, a+size) of the word are written; loads read the whole word
   function automatic logic [3:0] exp_be(input logic wr, input logic [1:0] bs, input logic [31:0] a);
      logic [3:0] be;
      int lo;
      be = 4'd0;
      lo = int'(a[1:0]);
      for (int i = 0; i < 4; i++) be[i] = !wr || (i >= lo && i < lo + size_of(bs));
      return be;
   endfunction

   // byte i on the bus carries store byte (i mod size)
   function automatic logic [31:0] exp_wdata(input logic [1:0] bs, input logic [31:0] d);
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % size_of(bs)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] bs, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * int'(a[1:0]));
      if (bs == 2'd0) return rd;
      if (bs == 2'd1) return v[15] ? (v & 32'hFFFF) - 32'h10000 : v & 32'hFFFF;
      if (bs == 2'd2) return v[7] ? (v & 32'hFF) - 32'h100 : v & 32'hFF;
      return v & 32'hFF;
   endfunction

   task automatic txn(input logic rd, input logic wr, input logic [1:0] bs, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rdat, input int waits);
      int stalls;
      @(negedge Clock);
      MemRead_In = rd; MemWrite_In = wr; ByteSel_In = bs; ALUResult_In = a; WriteData_In = wd;
      #1;
      if (is_illegal(rd, wr, bs, a)) begin
         chk("ill_stall", {31'd0, Stall}, 32'd0);
         @(negedge Clock);
         chk("misalign", {31'd0, Misalign_Out}, 32'd1);
         chk("ill_req", {31'd0, DMem_Req}, 32'd0);
         chk("ill_stall2", {31'd0, Stall}, 32'd0);
         MemRead_In = 1'b0; MemWrite_In = 1'b0;
         @(negedge Clock);
         chk("misalign_end", {31'd0, Misalign_Out}, 32'd0);
         chk("ill_req2", {31'd0, DMem_Req}, 32'd0);
      end else begin
         stalls = int'(Stall);
         for (int k = 0; k <= waits; k++) begin
            @(negedge Clock);
            stalls += int'(Stall);
            chk("req", {31'd0, DMem_Req}, 32'd1);
            chk("we", {31'd0, DMem_We}, {31'd0, wr});
            chk("addr", DMem_Addr, a & 32'hFFFF_FFFC);
            chk("byteen", {28'd0, DMem_ByteEn}, {28'd0, exp_be(wr, bs, a)});
            if (wr) chk("wdata", DMem_WData, exp_wdata(bs, wd));
            DMem_Ack = (k == waits);
            DMem_RData = (k == waits) ? rdat : $urandom;
         end
         @(negedge Clock);
         DMem_Ack = 1'b0;
         stalls += int'(Stall);
         chk("stall_cycles", stalls, waits + 2);
         chk("done_req", {31'd0, DMem_Req}, 32'd0);
         chk("rvalid", {31'd0, ReadValid_Out}, {31'd0, rd});
         chk("timeout_acked", {31'd0, Timeout_Out}, 32'd0);
         if (rd) begin
            last_load = exp_load(bs, a, rdat);
            chk("rdata", ReadData_Out, last_load);
         end
         MemRead_In = 1'b0; MemWrite_In = 1'b0;
         @(negedge Clock);
         chk("rvalid_end", {31'd0, ReadValid_Out}, 32'd0);
         chk("rdata_hold", ReadData_Out, last_load);
         chk("idle_stall", {31'd0, Stall}, 32'd0);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [1:0]  rbs;
      int          kind;
      Reset = 1'b0; MemRead_In = 1'b0; MemWrite_In = 1'b0; ByteSel_In = 2'd0;
      ALUResult_In = 32'd0; WriteData_In = 32'd0; DMem_Ack = 1'b0; DMem_RData = 32'd0;
      #12;
      chk("rst_stall", {31'd0, Stall}, 32'd0);
      chk("rst_req", {31'd0, DMem_Req}, 32'd0);
      chk("rst_rdata", ReadData_Out, 32'd0);
      chk("rst_rvalid", {31'd0, ReadValid_Out}, 32'd0);
      chk("rst_misalign", {31'd0, Misalign_Out}, 32'd0);
      chk("rst_timeout", {31'd0, Timeout_Out}, 32'd0);
      chk("rst_byteen", {28'd0, DMem_ByteEn}, 32'd0);
      chk("rst_addr", DMem_Addr, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;

      txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0, 32'hDEADBEEF, 2);
      chk("word_load_val", last_load, 32'hDEADBEEF);
      txn(1'b1, 1'b0, 2'd2, 32'h103, 32'd0, 32'h80FF_0000, 0);
      chk("lb_val", last_load, 32'hFFFFFF80);
      txn(1'b1, 1'b0, 2'd3, 32'h103, 32'd0, 32'h80FF_0000, 1);
      chk("lbu_val", last_load, 32'h00000080);
      txn(1'b0, 1'b1, 2'd1, 32'h202, 32'h1234ABCD, 32'd0, 0);
      txn(1'b1, 1'b0, 2'd0, 32'h101, 32'd0, 32'd0, 0);
      txn(1'b1, 1'b1, 2'd0, 32'h100, 32'd0, 32'd0, 0);
      txn(1'b0, 1'b1, 2'd2, 32'h3, 32'h0000_00A5, 32'd0, 3);
      txn(1'b1, 1'b0, 2'd1, 32'h6, 32'd0, 32'h8001_7FFF, 0);

      // reset during WAIT drops Req/Stall at once; a late Ack afterwards is ignored
      @(negedge Clock);
      MemRead_In = 1'b1; ByteSel_In = 2'd0; ALUResult_In = 32'h300;
      @(negedge Clock);
      chk("pre_rst_req", {31'd0, DMem_Req}, 32'd1);
      #2 Reset = 1'b0;
      #1;
      chk("async_req", {31'd0, DMem_Req}, 32'd0);
      chk("async_stall", {31'd0, Stall}, 32'd0);
      chk("async_rdata", ReadData_Out, 32'd0);
      last_load = 32'd0;
      @(negedge Clock);
      MemRead_In = 1'b0;
      Reset = 1'b1;
      DMem_Ack = 1'b1; DMem_RData = 32'h55AA55AA;
      @(negedge Clock);
      chk("late_ack_req", {31'd0, DMem_Req}, 32'd0);
      chk("late_ack_rvalid", {31'd0, ReadValid_Out}, 32'd0);
      chk("late_ack_stall", {31'd0, Stall}, 32'd0);
      @(negedge Clock);
      chk("late_ack_rdata", ReadData_Out, 32'd0);
      DMem_Ack = 1'b0;
      txn(1'b1, 1'b0, 2'd1, 32'h2, 32'd0, 32'h1234_5678, 1);

`ifdef MEM_TIMEOUT_EN
      @(negedge Clock);
      MemRead_In = 1'b1; ByteSel_In = 2'd0; ALUResult_In = 32'h400;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         chk("to_req", {31'd0, DMem_Req}, 32'd1);
         chk("to_pulse_early", {31'd0, Timeout_Out}, 32'd0);
      end
      @(negedge Clock);
      chk("to_pulse", {31'd0, Timeout_Out}, 32'd1);
      chk("to_req_drop", {31'd0, DMem_Req}, 32'd0);
      chk("to_stall", {31'd0, Stall}, 32'd0);
      chk("to_rvalid", {31'd0, ReadValid_Out}, 32'd0);
      chk("to_rdata", ReadData_Out, last_load);
      MemRead_In = 1'b0;
      @(negedge Clock);
      chk("to_pulse_end", {31'd0, Timeout_Out}, 32'd0);
`endif

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         ra = $urandom;
         rbs = 2'($urandom_range(0, 3));
         if (n % 2 == 0) ra[1:0] = (rbs == 2'd0) ? 2'd0 : (rbs == 2'd1) ? {ra[1], 1'b0} : ra[1:0];
         txn(kind != 1 && kind < 6 || kind == 9, kind >= 6 || kind == 1 || kind == 9, rbs, ra,
             $urandom, $urandom, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
